// File: rtl/cache_assoc_param_if.sv
// CPU request port and memory beat port of the set-associative cache controller.
// slave = cache controller side, master = CPU / memory environment side.
interface cache_assoc_param_if #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 8
);
  logic [AWIDTH-1:0] addr_cpu;
  logic              rd_cpu;
  logic              wr_cpu;
  logic [DWIDTH-1:0] data_cpu_in;
  logic [DWIDTH-1:0] data_cpu_out;
  logic              flush;
  logic              stall_cpu;
  logic              done_cpu;
  logic [AWIDTH-1:0] addr_mem;
  logic              rd_mem;
  logic              wr_mem;
  logic [DWIDTH-1:0] data_mem_out;
  logic [DWIDTH-1:0] data_mem_in;
  logic              ready_mem;

  modport slave (
    input  addr_cpu, rd_cpu, wr_cpu, data_cpu_in, flush, data_mem_in, ready_mem,
    output data_cpu_out, stall_cpu, done_cpu, addr_mem, rd_mem, wr_mem, data_mem_out
  );

  modport master (
    output addr_cpu, rd_cpu, wr_cpu, data_cpu_in, flush, data_mem_in, ready_mem,
    input  data_cpu_out, stall_cpu, done_cpu, addr_mem, rd_mem, wr_mem, data_mem_out
  );
endinterface

// File: rtl/cache_assoc_param.sv
// Parametrised set-associative cache controller with round-robin replacement,
// selectable write-back / write-through policy and a whole-cache flush command.
module cache_assoc_param #(
  parameter int AWIDTH     = 16,
  parameter int DWIDTH     = 8,
  parameter int WAYS       = 2,
  parameter int SETS       = 8,
  parameter int BLOCKSIZE  = 4,
  parameter int WRITE_MODE = 0
) (
  input logic clock,
  input logic reset,
  cache_assoc_param_if.slave bus
);
  localparam int OBITS = $clog2(BLOCKSIZE);
  localparam int IBITS = $clog2(SETS);
  localparam int TBITS = AWIDTH - OBITS - IBITS;
  localparam int WBITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, WTWRITE, FLUSH} state_t;
  state_t state, state_n;

  logic [SETS-1:0][WAYS-1:0]  valid, dirty;
  logic [SETS-1:0][WBITS-1:0] rr_ptr;
  logic [TBITS-1:0]  tag_mem  [SETS][WAYS];
  logic [DWIDTH-1:0] data_arr [SETS][WAYS][BLOCKSIZE];

  logic [AWIDTH-1:0] req_addr, req_addr_n;
  logic [DWIDTH-1:0] req_data, req_data_n;
  logic              req_write, req_write_n;
  logic [OBITS-1:0]  beat, beat_n;
  logic [WBITS-1:0]  victim, victim_n;
  logic [IBITS-1:0]  flush_set, flush_set_n;
  logic [WBITS-1:0]  flush_way, flush_way_n;

  logic              stall_q, stall_n, done_q, done_n, rd_q, rd_n, wr_q, wr_n;
  logic [DWIDTH-1:0] cpu_out_q, cpu_out_n, mem_out_q, mem_out_n;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_n;

  logic store_en, mark_dirty, fill_en, install_en, inval_all, flush_step, last_beat;

  logic [OBITS-1:0] req_off;
  logic [IBITS-1:0] req_idx;
  logic [TBITS-1:0] req_tag;
  logic             hit, has_free;
  logic [WBITS-1:0] hit_way, free_way, pick_way, rr_adv;

  assign req_off   = req_addr[OBITS-1:0];
  assign req_idx   = req_addr[OBITS +: IBITS];
  assign req_tag   = req_addr[AWIDTH-1 -: TBITS];
  assign last_beat = (beat == OBITS'(BLOCKSIZE - 1));

  // Tag compare for the latched request and victim choice: lowest free way, else round robin.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    has_free = 1'b0;
    free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WBITS'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[req_idx][w]) begin
        has_free = 1'b1;
        free_way = WBITS'(w);
      end
    end
    pick_way = has_free ? free_way : rr_ptr[req_idx];
    rr_adv   = (WAYS == 1) ? '0 : rr_ptr[req_idx] + WBITS'(1);
  end

  always_comb begin
    state_n     = state;
    req_addr_n  = req_addr;
    req_data_n  = req_data;
    req_write_n = req_write;
    beat_n      = beat;
    victim_n    = victim;
    flush_set_n = flush_set;
    flush_way_n = flush_way;
    stall_n     = stall_q;
    done_n      = 1'b0;
    cpu_out_n   = cpu_out_q;
    mem_addr_n  = mem_addr_q;
    mem_out_n   = mem_out_q;
    rd_n        = rd_q;
    wr_n        = wr_q;
    store_en    = 1'b0;
    mark_dirty  = 1'b0;
    fill_en     = 1'b0;
    install_en  = 1'b0;
    inval_all   = 1'b0;
    flush_step  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.flush) begin
          stall_n     = 1'b1;
          beat_n      = '0;
          flush_set_n = '0;
          flush_way_n = '0;
          state_n     = FLUSH;
        end else if ((bus.rd_cpu || bus.wr_cpu) && !done_q) begin
          // done_q blocks a request still held from the one that just completed
          req_addr_n  = bus.addr_cpu;
          req_data_n  = bus.data_cpu_in;
          req_write_n = !bus.rd_cpu;
          stall_n     = 1'b1;
          state_n     = LOOKUP;
        end
      end

      LOOKUP: begin
        if (hit) begin
          if (!req_write) begin
            cpu_out_n = data_arr[req_idx][hit_way][req_off];
            done_n    = 1'b1;
            stall_n   = 1'b0;
            state_n   = IDLE;
          end else begin
            store_en = 1'b1;
            if (WRITE_MODE == 0) begin
              mark_dirty = 1'b1;
              done_n     = 1'b1;
              stall_n    = 1'b0;
              state_n    = IDLE;
            end else begin
              state_n = WTWRITE;
            end
          end
        end else if (req_write && (WRITE_MODE != 0)) begin
          state_n = WTWRITE;
        end else begin
          victim_n = pick_way;
          beat_n   = '0;
          state_n  = (valid[req_idx][pick_way] && dirty[req_idx][pick_way]) ? EVICT : FILL;
        end
      end

      EVICT: begin
        if (!wr_q) begin
          wr_n       = 1'b1;
          mem_addr_n = {tag_mem[req_idx][victim], req_idx, beat};
          mem_out_n  = data_arr[req_idx][victim][beat];
        end else if (bus.ready_mem) begin
          wr_n = 1'b0;
          if (last_beat) begin
            beat_n  = '0;
            state_n = FILL;
          end else begin
            beat_n = beat + OBITS'(1);
          end
        end
      end

      FILL: begin
        if (!rd_q) begin
          rd_n       = 1'b1;
          mem_addr_n = {req_tag, req_idx, beat};
        end else if (bus.ready_mem) begin
          rd_n    = 1'b0;
          fill_en = 1'b1;
          if (last_beat) begin
            install_en = 1'b1;
            beat_n     = '0;
            state_n    = LOOKUP;
          end else begin
            beat_n = beat + OBITS'(1);
          end
        end
      end

      WTWRITE: begin
        if (!wr_q) begin
          wr_n       = 1'b1;
          mem_addr_n = req_addr;
          mem_out_n  = req_data;
        end else if (bus.ready_mem) begin
          wr_n    = 1'b0;
          done_n  = 1'b1;
          stall_n = 1'b0;
          state_n = IDLE;
        end
      end

      FLUSH: begin
        // Write-through lines are never dirty, so there is nothing to walk.
        if (WRITE_MODE != 0) begin
          inval_all = 1'b1;
          done_n    = 1'b1;
          stall_n   = 1'b0;
          state_n   = IDLE;
        end else if (wr_q) begin
          if (bus.ready_mem) begin
            wr_n = 1'b0;
            if (last_beat) begin
              beat_n     = '0;
              flush_step = 1'b1;
            end else begin
              beat_n = beat + OBITS'(1);
            end
          end
        end else if (valid[flush_set][flush_way] && dirty[flush_set][flush_way]) begin
          wr_n       = 1'b1;
          mem_addr_n = {tag_mem[flush_set][flush_way], flush_set, beat};
          mem_out_n  = data_arr[flush_set][flush_way][beat];
        end else begin
          flush_step = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase

    if (flush_step) begin
      if (flush_way == WBITS'(WAYS - 1)) begin
        flush_way_n = '0;
        if (flush_set == IBITS'(SETS - 1)) begin
          inval_all = 1'b1;
          done_n    = 1'b1;
          stall_n   = 1'b0;
          state_n   = IDLE;
        end else begin
          flush_set_n = flush_set + IBITS'(1);
        end
      end else begin
        flush_way_n = flush_way + WBITS'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_data   <= '0;
      req_write  <= 1'b0;
      beat       <= '0;
      victim     <= '0;
      flush_set  <= '0;
      flush_way  <= '0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
      cpu_out_q  <= '0;
      mem_addr_q <= '0;
      mem_out_q  <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      state      <= state_n;
      req_addr   <= req_addr_n;
      req_data   <= req_data_n;
      req_write  <= req_write_n;
      beat       <= beat_n;
      victim     <= victim_n;
      flush_set  <= flush_set_n;
      flush_way  <= flush_way_n;
      stall_q    <= stall_n;
      done_q     <= done_n;
      cpu_out_q  <= cpu_out_n;
      mem_addr_q <= mem_addr_n;
      mem_out_q  <= mem_out_n;
      rd_q       <= rd_n;
      wr_q       <= wr_n;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid  <= '0;
      dirty  <= '0;
      rr_ptr <= '0;
    end else begin
      if (inval_all) begin
        valid <= '0;
        dirty <= '0;
      end
      if (install_en) begin
        valid[req_idx][victim] <= 1'b1;
        dirty[req_idx][victim] <= 1'b0;
        rr_ptr[req_idx]        <= rr_adv;
      end
      if (mark_dirty) begin
        dirty[req_idx][hit_way] <= 1'b1;
      end
    end
  end

  // Line storage is meaningless until its valid bit is set, so it carries no reset.
  always_ff @(posedge clock) begin
    if (store_en) begin
      data_arr[req_idx][hit_way][req_off] <= req_data;
    end
    if (fill_en) begin
      data_arr[req_idx][victim][beat] <= bus.data_mem_in;
    end
    if (install_en) begin
      tag_mem[req_idx][victim] <= req_tag;
    end
  end

  assign bus.stall_cpu    = stall_q;
  assign bus.done_cpu     = done_q;
  assign bus.data_cpu_out = cpu_out_q;
  assign bus.addr_mem     = mem_addr_q;
  assign bus.rd_mem       = rd_q;
  assign bus.wr_mem       = wr_q;
  assign bus.data_mem_out = mem_out_q;
endmodule

// File: tb/tb_cache_assoc_param.sv
// Directed bench: one write-back and one write-through cache share a beat-level memory
// model; mode selects which one receives CPU requests and is observed.
`timescale 1ns/1ps
module tb_cache_assoc_param;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        mode = 1'b0;
  logic [15:0] addr_cpu = '0;
  logic        rd_cpu = 1'b0, wr_cpu = 1'b0, flush = 1'b0;
  logic [7:0]  data_cpu_in = '0;
  logic [7:0]  data_mem_in = '0;
  logic        ready_mem = 1'b0;
  int          ready_delay = 0;
  int          wait_cnt = 0;

  logic [15:0] addr_mem;
  logic        rd_mem, wr_mem, stall_cpu, done_cpu;
  logic [7:0]  data_mem_out, data_cpu_out;

  typedef struct packed {logic w; logic [15:0] a; logic [7:0] d;} beat_t;
  beat_t      log_q[$];
  beat_t      exp_q[$];
  logic [7:0] mem [0:65535];
  logic [7:0] over [int];
  int         total = 0, bad = 0;
  int         cyc;

  cache_assoc_param_if #(.AWIDTH(16), .DWIDTH(8)) if0 ();
  cache_assoc_param_if #(.AWIDTH(16), .DWIDTH(8)) if1 ();

  assign if0.addr_cpu    = addr_cpu;
  assign if0.data_cpu_in = data_cpu_in;
  assign if0.rd_cpu      = rd_cpu & ~mode;
  assign if0.wr_cpu      = wr_cpu & ~mode;
  assign if0.flush       = flush & ~mode;
  assign if0.data_mem_in = data_mem_in;
  assign if0.ready_mem   = ready_mem & ~mode;
  assign if1.addr_cpu    = addr_cpu;
  assign if1.data_cpu_in = data_cpu_in;
  assign if1.rd_cpu      = rd_cpu & mode;
  assign if1.wr_cpu      = wr_cpu & mode;
  assign if1.flush       = flush & mode;
  assign if1.data_mem_in = data_mem_in;
  assign if1.ready_mem   = ready_mem & mode;

  assign addr_mem     = mode ? if1.addr_mem     : if0.addr_mem;
  assign rd_mem       = mode ? if1.rd_mem       : if0.rd_mem;
  assign wr_mem       = mode ? if1.wr_mem       : if0.wr_mem;
  assign data_mem_out = mode ? if1.data_mem_out : if0.data_mem_out;
  assign stall_cpu    = mode ? if1.stall_cpu    : if0.stall_cpu;
  assign done_cpu     = mode ? if1.done_cpu     : if0.done_cpu;
  assign data_cpu_out = mode ? if1.data_cpu_out : if0.data_cpu_out;

  cache_assoc_param #(.WRITE_MODE(0)) dut0 (.clock(clock), .reset(reset), .bus(if0));
  cache_assoc_param #(.WRITE_MODE(1)) dut1 (.clock(clock), .reset(reset), .bus(if1));

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] exp_val(input logic [15:0] a);
    if (over.exists(int'(a))) return over[int'(a)];
    return pat(a);
  endfunction

  // Memory responder: acknowledges each strobe after ready_delay low cycles and logs the beat.
  always @(negedge clock) begin
    if (reset) begin
      ready_mem = 1'b0;
      wait_cnt  = 0;
    end else if ((rd_mem || wr_mem) && !ready_mem) begin
      if (wait_cnt >= ready_delay) begin
        ready_mem = 1'b1;
        wait_cnt  = 0;
        if (wr_mem) begin
          mem[addr_mem] = data_mem_out;
          log_q.push_back({1'b1, addr_mem, data_mem_out});
        end else begin
          data_mem_in = mem[addr_mem];
          log_q.push_back({1'b0, addr_mem, mem[addr_mem]});
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      ready_mem = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_burst(input logic w, input logic [15:0] base);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b = {w, base + 16'(i), exp_val(base + 16'(i))};
      exp_q.push_back(b);
    end
  endtask

  task automatic compare_log(input string tag);
    checkOutput({tag, "_beats"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      checkOutput($sformatf("%s_beat%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
      flush = 1'b0;
    end while (!done_cpu && cycles < 400);
    rd_cpu = 1'b0;
    wr_cpu = 1'b0;
    checkOutput({tag, "_done"}, done_cpu, 1'b1);
  endtask

  // kind: 0 read, 1 write, 2 flush, 3 read and write together
  task automatic applyStimulus(input string tag, input int kind, input logic [15:0] a,
                               input logic [7:0] d, output int cycles);
    @(negedge clock);
    log_q.delete();
    addr_cpu    = a;
    data_cpu_in = d;
    rd_cpu      = (kind == 0) || (kind == 3);
    wr_cpu      = (kind == 1) || (kind == 3);
    flush       = (kind == 2);
    wait_done(tag, cycles);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = pat(16'(a));
    mem[16'h0090] = 8'h11; mem[16'h0091] = 8'h22; mem[16'h0092] = 8'h33; mem[16'h0093] = 8'h44;
    over[16'h0090] = 8'h11; over[16'h0091] = 8'h22; over[16'h0092] = 8'h33; over[16'h0093] = 8'h44;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_stall", stall_cpu, 1'b0);
    checkOutput("rst_done", done_cpu, 1'b0);
    checkOutput("rst_rd_mem", rd_mem, 1'b0);
    checkOutput("rst_wr_mem", wr_mem, 1'b0);
    checkOutput("rst_addr_mem", addr_mem, 16'h0000);
    checkOutput("rst_data_out", data_cpu_out, 8'h00);

    // Write-back cache: cold miss, then hit latency
    exp_burst(1'b0, 16'h0090);
    applyStimulus("miss0093", 0, 16'h0093, 8'h00, cyc);
    compare_log("miss0093");
    checkOutput("miss0093_data", data_cpu_out, 8'h44);
    applyStimulus("hit0093", 0, 16'h0093, 8'h00, cyc);
    checkOutput("hit0093_latency", cyc, 2);
    compare_log("hit0093");
    checkOutput("hit0093_data", data_cpu_out, 8'h44);

    applyStimulus("wrhit0093", 1, 16'h0093, 8'h23, cyc);
    checkOutput("wrhit0093_latency", cyc, 2);
    compare_log("wrhit0093");

    // Two more tags in set 4: the second evicts the dirty 0x0090 line (round robin back to way 0)
    exp_burst(1'b0, 16'hC090);
    applyStimulus("fillC091", 0, 16'hC091, 8'h00, cyc);
    compare_log("fillC091");
    checkOutput("fillC091_data", data_cpu_out, pat(16'hC091));
    over[16'h0093] = 8'h23;
    exp_burst(1'b1, 16'h0090);
    exp_burst(1'b0, 16'hC110);
    applyStimulus("evict", 0, 16'hC113, 8'h00, cyc);
    compare_log("evict");
    checkOutput("evict_data", data_cpu_out, pat(16'hC113));

    // Slow memory: the first beat must hold while ready_mem stays low
    @(negedge clock);
    log_q.delete();
    ready_delay = 5;
    addr_cpu = 16'h2045;
    rd_cpu   = 1'b1;
    cyc = 0;
    while (!rd_mem && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hold%0d_rd_mem", i), rd_mem, 1'b1);
      checkOutput($sformatf("hold%0d_addr", i), addr_mem, 16'h2044);
      checkOutput($sformatf("hold%0d_stall", i), stall_cpu, 1'b1);
      @(negedge clock);
    end
    ready_delay = 0;
    wait_done("slow", cyc);
    exp_burst(1'b0, 16'h2044);
    compare_log("slow");
    checkOutput("slow_data", data_cpu_out, pat(16'h2045));

    // Dirty two lines, flush: set 1 way 0 then set 4 way 0 are written back
    applyStimulus("dirtyC113", 1, 16'hC113, 8'h55, cyc);
    applyStimulus("dirty2045", 1, 16'h2045, 8'h66, cyc);
    over[16'hC113] = 8'h55;
    over[16'h2045] = 8'h66;
    exp_burst(1'b1, 16'h2044);
    exp_burst(1'b1, 16'hC110);
    applyStimulus("flush0", 2, 16'h0000, 8'h00, cyc);
    compare_log("flush0");
    exp_burst(1'b0, 16'h2044);
    applyStimulus("postflush2045", 0, 16'h2045, 8'h00, cyc);
    compare_log("postflush2045");
    checkOutput("postflush2045_data", data_cpu_out, 8'h66);
    exp_burst(1'b0, 16'h0090);
    applyStimulus("postflush0093", 0, 16'h0093, 8'h00, cyc);
    compare_log("postflush0093");
    checkOutput("postflush0093_data", data_cpu_out, 8'h23);

    // Reset while the third fill beat is outstanding
    @(negedge clock);
    addr_cpu = 16'h3A07;
    rd_cpu   = 1'b1;
    cyc = 0;
    while (!(rd_mem && addr_mem == 16'h3A06) && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput("rstfill_reach", {rd_mem, addr_mem}, {1'b1, 16'h3A06});
    reset = 1'b1;
    @(negedge clock);
    checkOutput("rstfill_rd_mem", rd_mem, 1'b0);
    checkOutput("rstfill_stall", stall_cpu, 1'b0);
    reset  = 1'b0;
    rd_cpu = 1'b0;
    exp_burst(1'b0, 16'h3A04);
    applyStimulus("afterrst", 0, 16'h3A07, 8'h00, cyc);
    compare_log("afterrst");
    checkOutput("afterrst_data", data_cpu_out, pat(16'h3A07));

    // rd_cpu and wr_cpu together behave as a read; the line must stay unwritten
    applyStimulus("rdwr", 3, 16'h3A07, 8'hEE, cyc);
    checkOutput("rdwr_latency", cyc, 2);
    compare_log("rdwr");
    applyStimulus("rdwr_chk", 0, 16'h3A07, 8'h00, cyc);
    checkOutput("rdwr_chk_data", data_cpu_out, pat(16'h3A07));

    // Write-through cache
    @(negedge clock);
    reset = 1'b1;
    mode  = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    over[16'h0452] = 8'h77;
    exp_q.push_back({1'b1, 16'h0452, 8'h77});
    applyStimulus("wtmiss", 1, 16'h0452, 8'h77, cyc);
    compare_log("wtmiss");
    exp_burst(1'b0, 16'h0450);
    applyStimulus("wtnoalloc", 0, 16'h0452, 8'h00, cyc);
    compare_log("wtnoalloc");
    checkOutput("wtnoalloc_data", data_cpu_out, 8'h77);
    over[16'h0452] = 8'h88;
    exp_q.push_back({1'b1, 16'h0452, 8'h88});
    applyStimulus("wthit", 1, 16'h0452, 8'h88, cyc);
    compare_log("wthit");
    applyStimulus("wthit_rd", 0, 16'h0452, 8'h00, cyc);
    checkOutput("wthit_rd_latency", cyc, 2);
    checkOutput("wthit_rd_data", data_cpu_out, 8'h88);
    applyStimulus("wtflush", 2, 16'h0000, 8'h00, cyc);
    checkOutput("wtflush_latency", cyc, 2);
    compare_log("wtflush");
    exp_burst(1'b0, 16'h0450);
    applyStimulus("wtpostflush", 0, 16'h0452, 8'h00, cyc);
    compare_log("wtpostflush");
    checkOutput("wtpostflush_data", data_cpu_out, 8'h88);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
